// File: rtl/data_mem_io_if.sv
// CPU data-port bus plus TX byte stream for data_mem_io.
// The master side is the CPU and the byte consumer; the slave side is the memory/IO responder.
interface data_mem_io_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wmem;
    logic [31:0] rdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output addr, wdata, wmem, out_ready,
        input  rdata, out_data, out_valid
    );

    modport slave (
        input  addr, wdata, wmem, out_ready,
        output rdata, out_data, out_valid
    );
endinterface

// File: rtl/data_mem_io.sv
// Data-side responder for a single-cycle CPU: word RAM in the low half, and an I/O page
// (TX byte FIFO, status, cycle counter) in the high half. Loads are combinational.
module data_mem_io #(
    parameter int AW        = 10,
    parameter int FIFO_LOG2 = 2
) (
    input logic          clock,
    input logic          reset_n,
    data_mem_io_if.slave bus
);
    localparam int FIFO_DEPTH = 2**FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] DEPTH_CNT = FIFO_DEPTH;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_CYCLES = 2'd2,
        REG_RSVD   = 2'd3
    } io_reg_e;

    logic [31:0]          mem_q  [2**AW];
    logic [7:0]           fifo_q [FIFO_DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]   count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [31:0]          cyc_q, cyc_d;

    logic          sel_io;
    logic [AW-1:0] word_idx;
    io_reg_e       io_reg;
    logic          empty, full, pop, push_req, push;
    logic          ram_we, status_we, cycles_we;
    logic [31:0]   rdata;
    logic          unused_addr;

    // Upper RAM address bits and the byte offset are don't-cares, so RAM aliases.
    assign sel_io      = bus.addr[31];
    assign word_idx    = bus.addr[AW+1:2];
    assign io_reg      = io_reg_e'(bus.addr[3:2]);
    assign unused_addr = ^{bus.addr[30:AW+2], bus.addr[1:0]};

    assign ram_we    = bus.wmem && !sel_io;
    assign push_req  = bus.wmem && sel_io && (io_reg == REG_TXDATA);
    assign status_we = bus.wmem && sel_io && (io_reg == REG_STATUS);
    assign cycles_we = bus.wmem && sel_io && (io_reg == REG_CYCLES);

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);
    assign pop   = !empty && bus.out_ready;
    // A full FIFO still takes a push when the head leaves in the same edge.
    assign push  = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        cyc_d    = cyc_q + 32'd1;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
        if (push_req && !push)           ovf_d = 1'b1;
        if (status_we && bus.wdata[2])   ovf_d = 1'b0;
        if (cycles_we)                   cyc_d = bus.wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cyc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cyc_q    <= cyc_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by count_q.
    always_ff @(posedge clock) begin
        if (ram_we) mem_q[word_idx] <= bus.wdata;
        if (push)   fifo_q[wr_ptr_q] <= bus.wdata[7:0];
    end

    always_comb begin
        rdata = '0;
        if (!sel_io) begin
            rdata = mem_q[word_idx];
        end else begin
            case (io_reg)
                REG_STATUS: begin
                    rdata[0]             = empty;
                    rdata[1]             = full;
                    rdata[2]             = ovf_q;
                    rdata[4+FIFO_LOG2:4] = count_q;
                end
                REG_CYCLES: rdata = cyc_q;
                default:    ;
            endcase
        end
    end

    assign bus.rdata     = rdata;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_data_mem_io.sv
// Directed self-checking bench for data_mem_io: RAM, counter, TX FIFO and async reset.
module tb_data_mem_io;
    localparam logic [31:0] A_TX  = 32'h8000_0000;
    localparam logic [31:0] A_ST  = 32'h8000_0004;
    localparam logic [31:0] A_CYC = 32'h8000_0008;
    localparam logic [31:0] A_RSV = 32'h8000_000C;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    data_mem_io_if bus ();

    data_mem_io #(.AW(10), .FIFO_LOG2(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive a store for one edge; called and returns at posedge+1.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wmem  = 1'b1;
        @(posedge clock);
        #1;
        bus.wmem  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset_n = 1'b0;
        bus.addr = '0; bus.wdata = '0; bus.wmem = 1'b0; bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            errors++; $display("FAIL reset_out valid=%b data=%h exp 0/00", bus.out_valid, bus.out_data);
        end
        rd(A_ST, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL reset_status got %h exp 00000001", v); end
        rd(A_CYC, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_cycles got %h exp 00000000", v); end
    endtask

    task automatic test_counter;
        logic [31:0] v;
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        rd(A_CYC, v);
        checks++;
        if (v !== 32'd5) begin errors++; $display("FAIL cycles_5 got %h exp 00000005", v); end
        wr(A_CYC, 32'hFFFF_FFFE);
        rd(A_CYC, v);
        checks++;
        if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cycles_load got %h exp fffffffe", v); end
        @(posedge clock); #1;
        rd(A_CYC, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycles_max got %h exp ffffffff", v); end
        @(posedge clock); #1;
        rd(A_CYC, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL cycles_wrap got %h exp 00000000", v); end
    endtask

    task automatic test_ram;
        logic [31:0] v;
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_0014, 32'h1234_5678);
        rd(32'h0000_0010, v);
        checks++;
        if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_w4 got %h exp deadbeef", v); end
        rd(32'h0000_0014, v);
        checks++;
        if (v !== 32'h1234_5678) begin errors++; $display("FAIL ram_w5 got %h exp 12345678", v); end
        rd(32'h0000_1010, v);
        checks++;
        if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias got %h exp deadbeef", v); end
        // Store in flight: the read before the edge must still see the old word.
        bus.addr = 32'h0000_0014; bus.wdata = 32'hCAFE_F00D; bus.wmem = 1'b1;
        #1;
        checks++;
        if (bus.rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL ram_rd_during_wr got %h exp 12345678", bus.rdata);
        end
        @(posedge clock); #1;
        bus.wmem = 1'b0;
        rd(32'h0000_0014, v);
        checks++;
        if (v !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_overwrite got %h exp cafef00d", v); end
        rd(A_TX, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL txdata_read got %h exp 00000000", v); end
        wr(A_RSV, 32'hFFFF_FFFF);
        rd(A_RSV, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reserved_read got %h exp 00000000", v); end
    endtask

    task automatic test_fifo_fill;
        logic [31:0] v;
        bus.out_ready = 1'b0;
        wr(A_TX, 32'hFFFF_FF41);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h41) begin
            errors++; $display("FAIL first_push valid=%b data=%h exp 1/41", bus.out_valid, bus.out_data);
        end
        wr(A_TX, 32'h42); wr(A_TX, 32'h43); wr(A_TX, 32'h44);
        rd(A_ST, v);
        checks++;
        if (v !== 32'h42) begin errors++; $display("FAIL status_full got %h exp 00000042", v); end
        wr(A_TX, 32'h45);
        rd(A_ST, v);
        checks++;
        if (v !== 32'h46) begin errors++; $display("FAIL status_overflow got %h exp 00000046", v); end
        checks++;
        if (bus.out_data !== 8'h41) begin errors++; $display("FAIL head_after_drop got %h exp 41", bus.out_data); end
        wr(A_ST, 32'h4);
        rd(A_ST, v);
        checks++;
        if (v !== 32'h42) begin errors++; $display("FAIL overflow_clear got %h exp 00000042", v); end
    endtask

    task automatic test_drain;
        logic [31:0] v;
        logic [7:0]  exp_b;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'h41 + 8'(i);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_b) begin
                errors++; $display("FAIL drain_%0d valid=%b data=%h exp 1/%h", i, bus.out_valid, bus.out_data, exp_b);
            end
            @(posedge clock); #1;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            errors++; $display("FAIL drain_empty valid=%b data=%h exp 0/00", bus.out_valid, bus.out_data);
        end
        rd(A_ST, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL drain_status got %h exp 00000001", v); end
    endtask

    task automatic test_full_pop;
        logic [31:0] v;
        logic [7:0]  exp_q [4];
        exp_q = '{8'h52, 8'h53, 8'h54, 8'h55};
        bus.out_ready = 1'b0;
        wr(A_TX, 32'h51); wr(A_TX, 32'h52); wr(A_TX, 32'h53); wr(A_TX, 32'h54);
        bus.out_ready = 1'b1;
        wr(A_TX, 32'h55);
        bus.out_ready = 1'b0;
        rd(A_ST, v);
        checks++;
        if (v !== 32'h42) begin errors++; $display("FAIL full_pop_status got %h exp 00000042", v); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[i]) begin
                errors++; $display("FAIL full_pop_drain_%0d valid=%b data=%h exp 1/%h", i, bus.out_valid, bus.out_data, exp_q[i]);
            end
            @(posedge clock); #1;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_pop_empty valid=%b exp 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        wr(A_TX, 32'h61); wr(A_TX, 32'h62); wr(A_TX, 32'h63);
        wr(A_CYC, 32'd99);
        @(posedge clock); #1;
        rd(A_CYC, v);
        checks++;
        if (v !== 32'd100) begin errors++; $display("FAIL pre_reset_cycles got %0d exp 100", v); end
        rd(A_ST, v);
        checks++;
        if (v !== 32'h30) begin errors++; $display("FAIL pre_reset_status got %h exp 00000030", v); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            errors++; $display("FAIL mid_reset_out valid=%b data=%h exp 0/00", bus.out_valid, bus.out_data);
        end
        #1;
        reset_n = 1'b1;
        rd(A_ST, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL post_reset_status got %h exp 00000001", v); end
        rd(A_CYC, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL post_reset_cycles got %h exp 00000000", v); end
        rd(32'h0000_0010, v);
        checks++;
        if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL post_reset_ram got %h exp deadbeef", v); end
        @(posedge clock); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_counter();
        test_ram();
        test_fifo_fill();
        test_drain();
        test_full_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
